// File: rtl/buzzer_pkg.sv
// rtl/buzzer_pkg.sv - shared types and constants for the buzzer output stage
package buzzer_pkg;

    localparam int PWM_BITS = 8;
    localparam int ENV_MAX  = 255;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } env_state_t;

endpackage

// File: rtl/buzzer_pwm.sv
// rtl/buzzer_pwm.sv - free-running PWM with duty reloaded only at period wrap
module buzzer_pwm
    import buzzer_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [PWM_BITS-1:0] pending_duty,
    output logic                pwm_out
);

    localparam logic [PWM_BITS-1:0] CNT_LAST = {PWM_BITS{1'b1}};

    logic [PWM_BITS-1:0] cnt;
    logic [PWM_BITS-1:0] duty;

    // Counter, wrap-synchronous duty reload (keeps periods glitch-free), registered compare
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            duty    <= '0;
            pwm_out <= 1'b0;
        end else begin
            cnt     <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
                duty <= pending_duty;
            end
            pwm_out <= (cnt < duty);
        end
    end

endmodule

// File: rtl/buzzer_env_pwm.sv
// rtl/buzzer_env_pwm.sv - gated ADSR envelope, volume scaling and PWM buzzer drive
module buzzer_env_pwm
    import buzzer_pkg::*;
#(
    parameter int ENV_DIV = 64
)(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] sample_in,
    input  logic        sample_valid,
    input  logic        gate,
    input  logic [7:0]  attack_rate,
    input  logic [7:0]  decay_rate,
    input  logic [7:0]  sustain_level,
    input  logic [7:0]  release_rate,
    input  logic [7:0]  volume,
    output logic        pwm_out,
    output logic [7:0]  env_level,
    output logic [2:0]  env_state,
    output logic        busy
);

    localparam logic [15:0] DIV_LAST = 16'(ENV_DIV - 1);
    localparam logic [8:0]  ENV_TOP  = 9'(ENV_MAX);

    env_state_t  state;
    logic [15:0] presc;
    logic        gate_d;
    logic        tick;
    logic        gate_rise;
    logic        gate_fall;
    logic [8:0]  att_sum;
    logic [8:0]  dec_diff;
    logic [8:0]  rel_diff;
    logic [15:0] prod_env;
    logic [15:0] prod_vol;
    logic [7:0]  pending_duty;
    logic        unused_lsbs;

    assign tick      = sample_valid && (presc == DIV_LAST);
    assign gate_rise = gate & ~gate_d;
    assign gate_fall = ~gate & gate_d;

    // Bit 8 of the differences flags an underflow below zero
    assign att_sum  = {1'b0, env_level} + {1'b0, attack_rate};
    assign dec_diff = {1'b0, env_level} - {1'b0, decay_rate};
    assign rel_diff = {1'b0, env_level} - {1'b0, release_rate};

    // Two 8x8 multiplies, each keeping the top byte
    assign prod_env = sample_in[15:8] * env_level;
    assign prod_vol = prod_env[15:8] * volume;

    assign unused_lsbs = ^{sample_in[7:0], prod_env[7:0], prod_vol[7:0]};

    assign env_state = state;
    assign busy      = (state != ST_IDLE);

    // Envelope tick prescaler counting sample strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
        end else if (sample_valid) begin
            presc <= (presc == DIV_LAST) ? 16'd0 : presc + 16'd1;
        end
    end

    // Scaled sample captured on each strobe, using the envelope from before the strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_duty <= '0;
        end else if (sample_valid) begin
            pending_duty <= prod_vol[15:8];
        end
    end

    // Envelope FSM: gate edges take priority over the tick update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gate_d    <= 1'b0;
            state     <= ST_IDLE;
            env_level <= '0;
        end else begin
            gate_d <= gate;
            if (gate_rise) begin
                state <= ST_ATTACK;
            end else if (gate_fall && (state == ST_ATTACK || state == ST_DECAY ||
                                       state == ST_SUSTAIN)) begin
                state <= ST_RELEASE;
            end else if (tick) begin
                case (state)
                    ST_ATTACK: begin
                        if (attack_rate == 8'd0 || att_sum >= ENV_TOP) begin
                            env_level <= ENV_TOP[7:0];
                            state     <= ST_DECAY;
                        end else begin
                            env_level <= att_sum[7:0];
                        end
                    end
                    ST_DECAY: begin
                        if (decay_rate == 8'd0 || dec_diff[8] || dec_diff[7:0] <= sustain_level) begin
                            env_level <= sustain_level;
                            state     <= ST_SUSTAIN;
                        end else begin
                            env_level <= dec_diff[7:0];
                        end
                    end
                    ST_SUSTAIN: begin
                        env_level <= sustain_level;
                    end
                    ST_RELEASE: begin
                        if (release_rate == 8'd0 || rel_diff[8] || rel_diff[7:0] == 8'd0) begin
                            env_level <= 8'd0;
                            state     <= ST_IDLE;
                        end else begin
                            env_level <= rel_diff[7:0];
                        end
                    end
                    default: begin
                        env_level <= 8'd0;
                    end
                endcase
            end
        end
    end

    buzzer_pwm u_pwm (
        .clk          (clk),
        .rst          (rst),
        .pending_duty (pending_duty),
        .pwm_out      (pwm_out)
    );

endmodule

// File: tb/tb_buzzer_env_pwm.sv
// tb/tb_buzzer_env_pwm.sv - directed self-checking bench for buzzer_env_pwm
module tb_buzzer_env_pwm;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] sample_in;
    logic        sample_valid;
    logic        gate;
    logic [7:0]  attack_rate;
    logic [7:0]  decay_rate;
    logic [7:0]  sustain_level;
    logic [7:0]  release_rate;
    logic [7:0]  volume;
    logic        pwm_out;
    logic [7:0]  env_level;
    logic [2:0]  env_state;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    buzzer_env_pwm #(.ENV_DIV(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .sample_in     (sample_in),
        .sample_valid  (sample_valid),
        .gate          (gate),
        .attack_rate   (attack_rate),
        .decay_rate    (decay_rate),
        .sustain_level (sustain_level),
        .release_rate  (release_rate),
        .volume        (volume),
        .pwm_out       (pwm_out),
        .env_level     (env_level),
        .env_state     (env_state),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One sample strobe followed by 9 idle cycles
    task automatic pulse_sv();
        @(negedge clk) sample_valid = 1'b1;
        @(negedge clk) sample_valid = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    // Four strobes = one envelope tick with ENV_DIV=4
    task automatic tick_env();
        repeat (4) pulse_sv();
    endtask

    task automatic tick_check(input string tag, input int exp_env, input int exp_state);
        tick_env();
        check({tag, "_env"}, env_level, exp_env);
        check({tag, "_state"}, env_state, exp_state);
    endtask

    task automatic set_gate(input logic g);
        @(negedge clk) gate = g;
        @(negedge clk);
    endtask

    // Counts pwm_out high cycles over one full period; optionally strobes a new
    // sample with volume inj_vol when the counter reads 50
    task automatic measure_period(input string tag, input bit inject,
                                  input logic [7:0] inj_vol, input int exp_high);
        int  highs;
        bit  found;
        highs = 0;
        found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            @(negedge clk);
            if (dut.u_pwm.cnt == 8'd255) found = 1'b1;
        end
        if (!found) begin
            check({tag, "_wrap_timeout"}, 0, 1);
        end else begin
            for (int i = 1; i <= 257; i++) begin
                @(negedge clk);
                if (inject && dut.u_pwm.cnt == 8'd50) begin
                    volume       = inj_vol;
                    sample_valid = 1'b1;
                end else begin
                    sample_valid = 1'b0;
                end
                if (i >= 2 && pwm_out) highs++;
            end
            sample_valid = 1'b0;
            check(tag, highs, exp_high);
        end
    endtask

    initial begin
        rst           = 1'b1;
        gate          = 1'b1;
        sample_in     = 16'h0000;
        sample_valid  = 1'b0;
        attack_rate   = 8'd100;
        decay_rate    = 8'd50;
        sustain_level = 8'd128;
        release_rate  = 8'd64;
        volume        = 8'd255;

        // Reset with gate held high
        repeat (3) @(negedge clk);
        check("rst_pwm", pwm_out, 0);
        check("rst_env", env_level, 0);
        check("rst_state", env_state, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_attack", env_state, 1);
        check("post_rst_busy", busy, 1);

        // Attack / decay / sustain
        tick_check("att1", 100, 1);
        tick_check("att2", 200, 1);
        tick_check("att3", 255, 2);
        tick_check("dec1", 205, 2);
        tick_check("dec2", 155, 2);
        tick_check("dec3", 128, 3);
        tick_check("sus", 128, 3);

        // Release, then retrigger from 64
        set_gate(1'b0);
        check("fall_state", env_state, 4);
        check("fall_env", env_level, 128);
        tick_check("rel1", 64, 4);
        set_gate(1'b1);
        check("retrig_state", env_state, 1);
        check("retrig_env", env_level, 64);
        tick_check("retrig_att", 164, 1);
        tick_check("retrig_att2", 255, 2);
        tick_check("dec1b", 205, 2);
        tick_check("dec2b", 155, 2);
        tick_check("dec3b", 128, 3);
        set_gate(1'b0);
        check("fall2_state", env_state, 4);
        tick_check("rel1b", 64, 4);
        tick_check("rel2b", 0, 0);
        check("idle_busy", busy, 0);

        // Instant attack, sustain at full scale
        attack_rate   = 8'd0;
        sustain_level = 8'd255;
        set_gate(1'b1);
        check("att0_state", env_state, 1);
        check("att0_env_kept", env_level, 0);
        tick_check("att0", 255, 2);
        tick_check("sus255", 255, 3);

        // Duty measurements
        sample_in = 16'hFF00;
        volume    = 8'd255;
        pulse_sv();
        measure_period("duty253", 1'b0, 8'd0, 253);
        volume = 8'd0;
        pulse_sv();
        measure_period("vol0", 1'b0, 8'd0, 0);
        volume    = 8'd255;
        sample_in = 16'h0000;
        pulse_sv();
        measure_period("sample0", 1'b0, 8'd0, 0);

        // Glitch-free reload: pending 10 -> 200 mid-period
        sample_in = 16'hFF00;
        volume    = 8'd11;
        pulse_sv();
        measure_period("duty10", 1'b0, 8'd0, 10);
        measure_period("duty10_kept", 1'b1, 8'd202, 10);
        measure_period("duty200", 1'b0, 8'd0, 200);

        // Reset mid-note
        @(negedge clk);
        while (!pwm_out) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_pwm", pwm_out, 0);
        check("midrst_state", env_state, 0);
        check("midrst_env", env_level, 0);
        @(negedge clk) rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/buzzer_env_pwm.md
# buzzer_env_pwm

Output stage of the buzzer audio path. Consumes the 16-bit sample and one-cycle `start` strobe produced by any waveform generator (sine, noise, square, triangle, saw). Applies a gated attack/decay/sustain/release envelope and a master volume, then drives the single-bit buzzer pin with an 8-bit, glitch-free PWM.

## Interface

Reset `rst` is asynchronous and active-high; clock is `clk`.

Parameters:
- `ENV_DIV`, default 64: number of `sample_valid` strobes per envelope tick. Legal range 1..65535.

Ports:
- `clk` in 1: system clock
- `rst` in 1: asynchronous, active-high reset
- `sample_in` in 16: unsigned generator sample; only `[15:8]` is used
- `sample_valid` in 1: one-cycle strobe, connected to the generator `start`
- `gate` in 1: note on (1) / note off (0), level-sensitive
- `attack_rate` in 8: envelope increment per tick; 0 = instant
- `decay_rate` in 8: envelope decrement per tick in DECAY; 0 = instant
- `sustain_level` in 8: sustain target
- `release_rate` in 8: envelope decrement per tick in RELEASE; 0 = instant
- `volume` in 8: master volume, 255 = full scale
- `pwm_out` out 1: buzzer pin
- `env_level` out 8: current envelope value
- `env_state` out 3: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4
- `busy` out 1: high whenever `env_state` is not IDLE

## Operation

Reset values:
- All outputs 0; `env_state` is IDLE.
- Internal state is also 0: prescaler, `gate_d`, `pending_duty`, `duty`, PWM counter.

Gate edges:
- `gate_d` is a registered copy of `gate`.
- Rise (`gate & ~gate_d`), from any state including RELEASE and ATTACK: go to ATTACK. `env_level` is kept, not cleared.
- Fall (`~gate & gate_d`) in ATTACK, DECAY or SUSTAIN: go to RELEASE. A fall in IDLE or RELEASE is ignored.

Envelope tick:
- The prescaler increments on each `sample_valid`.
- When it equals `ENV_DIV-1` and `sample_valid` is high, it wraps to 0 and a tick fires.

Per-tick state behaviour (all arithmetic saturates on 9-bit intermediates):
- ATTACK: `env += attack_rate`, clamped at 255. On reaching 255, go to DECAY. Rate 0 sets 255 immediately.
- DECAY: `env -= decay_rate`, floored at `sustain_level`. On reaching `sustain_level`, go to SUSTAIN. Rate 0 jumps to it.
- If `sustain_level` is 255, DECAY passes straight to SUSTAIN on its first tick.
- SUSTAIN: `env = sustain_level` every tick, so live changes are tracked.
- RELEASE: `env -= release_rate`, floored at 0. On reaching 0, go to IDLE. Rate 0 goes to 0 immediately.
- IDLE: `env` stays 0.

Sample scaling, evaluated on the `sample_valid` edge:
- `pending_duty = ((sample_in[15:8] * env_level)[15:8] * volume)[15:8]`.
- This uses the `env_level` value from before that edge.

PWM:
- The 8-bit counter free-runs 0..255.
- `duty` loads from `pending_duty` only on the edge where the counter wraps 255→0.
- `pwm_out = (cnt < duty)`, registered.
- Duty 0 gives a constant low; duty 255 gives high for 255 of every 256 cycles.

## Timing

- Gate edge to `env_state` change: 1 cycle after `gate` is first sampled changed.
- Edge and tick on the same clock: the edge transition wins and the level is not updated on that tick. The prescaler still wraps.
- Tick to `env_level` update: same edge, visible the next cycle.
- `sample_valid` to `pending_duty`: 1 cycle.
- `pending_duty` to `duty`: at the next counter wrap, at most 256 cycles.
- `duty` to `pwm_out`: 1 cycle.
- `sample_valid` back-to-back every cycle is legal. A `pending_duty` value overwritten before a wrap is simply lost.
- Reset mid-note: immediate IDLE, `pwm_out` 0. The first PWM period after release starts at `cnt` = 0.

## Structure

- Shared package `buzzer_pkg`:
  - `env_state_t` encoding.
  - Constants `PWM_BITS`=8 and `ENV_MAX`=255.
- Sub-module `buzzer_pwm`: counter, double-buffered `duty`, compare.
- Envelope FSM, prescaler and scaling multiplies live in the top level.

## Test plan

1. Reset with `gate`=1: all outputs 0 during `rst`. ATTACK starts 1 cycle after `rst` deasserts.
2. Envelope sequence:
   - Setup: `ENV_DIV`=4, `sample_valid` every 10 cycles, attack 100, decay 50, sustain 128, release 64; gate held high.
   - ATTACK: `env_level` 100, 200, 255.
   - DECAY: 205, 155, 128, then SUSTAIN.
   - Drop gate: RELEASE 64, 0, then IDLE with `busy`=0.
3. Retrigger: gate rises while in RELEASE with `env`=64 → ATTACK continues upward from 64 (164 at the next tick with rate 100), not from 0.
4. Duty: `sample_in`=0xFF00, `env`=255, `volume`=255 → `duty` 253 after the next wrap. `pwm_out` high 253 of 256 cycles.
5. Zero cases:
   - `volume`=0 → `pwm_out` held low.
   - `sample_in`=0x0000 → low.
   - `attack_rate`=0 → `env` 255 after one tick.
6. Glitch-free update: change `pending_duty` from 10 to 200 mid-period at `cnt`=50 → the current period keeps a high time of 10. The next period's high time is 200.
